// File: rtl/seg_scroll_display_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scroll_display_if
//  Brief    : Bundle of value/control inputs and display outputs for the
//             scrolling seven-segment driver.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scroll_display_if #(
   parameter int DIGITS  = 4,
   parameter int NIBBLES = 8
);
   localparam int PW = $clog2(NIBBLES);

   logic [4*NIBBLES-1:0] num;
   logic                 load;
   logic [1:0]           mode;
   logic                 hold;
   logic [6:0]           seg;
   logic                 dp;
   logic [DIGITS-1:0]    an;
   logic [PW-1:0]        pos;

   // Board-side controller: supplies the value and the scroll controls
   modport master (output num, load, mode, hold, input seg, dp, an, pos);
   // Display driver
   modport slave  (input num, load, mode, hold, output seg, dp, an, pos);
endinterface
`default_nettype wire

// File: rtl/seg_scroll_display.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scroll_display
//  Brief    : Multiplexed seven-segment driver showing a DIGITS-wide window
//             onto an NIBBLES-nibble hex value, with static / bounce / wrap
//             scrolling and frame-boundary (tear-free) value updates.
//             Optional macro SEG_LEADING_ZERO_BLANK_EN: blank leading zero
//             digits in static mode.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scroll_display #(
   parameter int DIGITS     = 4,
   parameter int NIBBLES    = 8,
   parameter int SCAN_DIV   = 125000,
   parameter int SCROLL_DIV = 25000000
) (
   input  wire logic             clk,
   input  wire logic             rst,
   seg_scroll_display_if.slave   bus
);
   localparam int SCAN_W   = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int SW       = $clog2(DIGITS);
   localparam int PW       = $clog2(NIBBLES);
   localparam int VW       = 4*NIBBLES;

   localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV-1);
   localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV-1);
   localparam logic [SW-1:0]       S_LAST      = SW'(DIGITS-1);
   localparam logic [PW-1:0]       P_LAST      = PW'(NIBBLES-1);
   localparam logic [PW-1:0]       MAXPOS      = PW'(NIBBLES-DIGITS);
   localparam logic [PW:0]         NIB_CNT     = (PW+1)'(NIBBLES);
   localparam logic [DIGITS-1:0]   AN_RST      = {1'b0, {(DIGITS-1){1'b1}}};
   localparam logic [1:0]          MODE_BOUNCE = 2'b01;
   localparam logic [1:0]          MODE_WRAP   = 2'b10;

   logic [SCAN_W-1:0]   scan_cnt_q,   scan_cnt_d;
   logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
   logic [SW-1:0]       s_q,          s_d;
   logic [PW-1:0]       pos_q,        pos_d;
   logic                dir_dn_q,     dir_dn_d;
   logic [1:0]          mode_q;
   logic [VW-1:0]       shadow_q,     shadow_d;
   logic [VW-1:0]       pend_q,       pend_d;
   logic                pending_q,    pending_d;
   logic [6:0]          seg_q,        seg_d;
   logic                dp_q,         dp_d;
   logic [DIGITS-1:0]   an_q,         an_d;

   logic                scan_tick, scroll_tick, frame_end, mode_chg;
   logic [PW:0]         win_sum;
   logic [PW-1:0]       nib_idx;
   logic [VW-1:0]       nib_sh;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
      endcase
   endfunction

   // Tick generation, scan index, window position and value buffering
   always_comb begin
      scan_tick    = (scan_cnt_q == SCAN_LAST);
      scroll_tick  = (scroll_cnt_q == SCROLL_LAST);
      frame_end    = scan_tick && (s_q == S_LAST);
      mode_chg     = (bus.mode != mode_q);

      scan_cnt_d   = scan_tick   ? '0 : scan_cnt_q + 1'b1;
      scroll_cnt_d = scroll_tick ? '0 : scroll_cnt_q + 1'b1;
      s_d          = s_q;
      if (scan_tick) s_d = frame_end ? '0 : s_q + 1'b1;

      pos_d    = pos_q;
      dir_dn_d = dir_dn_q;
      // A mode change restarts scrolling from a known origin and phase
      if (mode_chg) begin
         pos_d        = '0;
         dir_dn_d     = 1'b0;
         scroll_cnt_d = '0;
      end else if (scroll_tick && !bus.hold) begin
         case (bus.mode)
            MODE_BOUNCE: begin
               // The turn-around step dwells on the end position
               if (!dir_dn_q) begin
                  if (pos_q == MAXPOS) dir_dn_d = 1'b1;
                  else                 pos_d    = pos_q + 1'b1;
               end else begin
                  if (pos_q == '0)     dir_dn_d = 1'b0;
                  else                 pos_d    = pos_q - 1'b1;
               end
            end
            MODE_WRAP: pos_d = (pos_q == P_LAST) ? '0 : pos_q + 1'b1;
            default:   pos_d = '0;
         endcase
      end

      shadow_d  = shadow_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      // A load landing on the boundary itself bypasses the pending buffer
      if (bus.load && frame_end) begin
         shadow_d  = bus.num;
         pending_d = 1'b0;
      end else if (bus.load) begin
         pend_d    = bus.num;
         pending_d = 1'b1;
      end else if (frame_end && pending_q) begin
         shadow_d  = pend_q;
         pending_d = 1'b0;
      end
   end

   // Digit content for the next scan step, built from next-state values so
   // the registered outputs always match the s they are shown with
   always_comb begin
      win_sum = {1'b0, pos_d} + {{(PW+1-SW){1'b0}}, s_d};
      if (win_sum > {1'b0, P_LAST}) win_sum = win_sum - NIB_CNT;
      nib_idx = P_LAST - win_sum[PW-1:0];
      nib_sh  = shadow_d >> {nib_idx, 2'b00};
      seg_d   = hex7(nib_sh[3:0]);
      dp_d    = !(((nib_idx == P_LAST) && (s_d == '0)) ||
                  ((nib_idx == '0) && (s_d == S_LAST)));
      an_d    = ~(DIGITS'(1) << (S_LAST - s_d));
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if ((bus.mode != MODE_BOUNCE) && (bus.mode != MODE_WRAP) &&
          (s_d != S_LAST) && (nib_sh == '0)) begin
         seg_d = 7'b1111111;
         dp_d  = 1'b1;
      end
`endif
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q   <= '0;
         scroll_cnt_q <= '0;
         s_q          <= '0;
         pos_q        <= '0;
         dir_dn_q     <= 1'b0;
         mode_q       <= bus.mode;
         shadow_q     <= '0;
         pend_q       <= '0;
         pending_q    <= 1'b0;
      end else begin
         scan_cnt_q   <= scan_cnt_d;
         scroll_cnt_q <= scroll_cnt_d;
         s_q          <= s_d;
         pos_q        <= pos_d;
         dir_dn_q     <= dir_dn_d;
         mode_q       <= bus.mode;
         shadow_q     <= shadow_d;
         pend_q       <= pend_d;
         pending_q    <= pending_d;
      end
   end

   // Display outputs change only together with the scan index
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= 7'b0000001;
         dp_q  <= 1'b0;
         an_q  <= AN_RST;
      end else if (scan_tick) begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.an  = an_q;
   assign bus.pos = pos_q;
endmodule
`default_nettype wire
